// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce family: default limits used by the
// key-scan and menu-button tops, counter sizing and the per-channel flag bundle.
package debounce_pkg;

    localparam int DEFAULT_NUM_CH         = 8;
    localparam int DEFAULT_DEBOUNCE_LIMIT = 20;
    localparam int DEFAULT_HOLD_LIMIT     = 1000;
    localparam int DEFAULT_REPEAT_PERIOD  = 250;

    typedef struct packed {
        logic debounced;
        logic rise;
        logic fall;
        logic held;
        logic rpt;
    } ch_flags_t;

    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced key: two-flop synchroniser with optional inversion, stability
// counter, registered edge pulses, long-press flag and auto-repeat pulse train.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int   HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter int   REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD,
    parameter logic INVERT         = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bouncy_i,
    input  logic repeat_en_i,
    output logic debounced_o,
    output logic rise_o,
    output logic fall_o,
    output logic held_o,
    output logic repeat_o
);

    localparam int DW = cnt_width(DEBOUNCE_LIMIT);
    localparam int HW = cnt_width(HOLD_LIMIT + 1);
    localparam int RW = cnt_width(REPEAT_PERIOD);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    logic            sync1_q;
    logic            sync2_q;
    logic [DW-1:0]   deb_cnt_q;
    logic [DW-1:0]   deb_cnt_d;
    logic [HW-1:0]   hold_cnt_q;
    logic [HW-1:0]   hold_cnt_d;
    logic [RW-1:0]   rep_cnt_q;
    logic [RW-1:0]   rep_cnt_d;
    ch_flags_t       flags_q;
    ch_flags_t       flags_d;
    logic            accept_s;
    logic            level_s;
    logic            fire_s;

    // Stability counter: any sample matching the accepted level discards progress.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        accept_s  = 1'b0;
        if (sync2_q == flags_q.debounced) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_d = '0;
            accept_s  = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
        if (accept_s) begin
            level_s = sync2_q;
        end else begin
            level_s = flags_q.debounced;
        end
    end

    // Hold counter only advances on cycles already showing the pressed level,
    // so the release edge clears it together with the fall pulse.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!level_s) begin
            hold_cnt_d = '0;
        end else if (flags_q.debounced && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Repeat phase starts at the hold threshold; the enable only gates the pulse.
    always_comb begin
        rep_cnt_d = '0;
        fire_s    = 1'b0;
        if (!level_s) begin
            rep_cnt_d = '0;
            fire_s    = 1'b0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            rep_cnt_d = '0;
            fire_s    = (hold_cnt_d == HOLD_MAX);
        end else if (rep_cnt_q == REP_MAX) begin
            rep_cnt_d = '0;
            fire_s    = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
            fire_s    = 1'b0;
        end
    end

    // Next-state output flags.
    always_comb begin
        flags_d           = '0;
        flags_d.debounced = level_s;
        flags_d.rise      = accept_s & sync2_q;
        flags_d.fall      = accept_s & ~sync2_q;
        flags_d.held      = level_s & (hold_cnt_d == HOLD_MAX);
        flags_d.rpt       = fire_s & repeat_en_i;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            flags_q    <= '0;
        end else begin
            sync1_q    <= bouncy_i ^ INVERT;
            sync2_q    <= sync1_q;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            flags_q    <= flags_d;
        end
    end

    assign debounced_o = flags_q.debounced;
    assign rise_o      = flags_q.rise;
    assign fall_o      = flags_q.fall;
    assign held_o      = flags_q.held;
    assign repeat_o    = flags_q.rpt;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced key channels between board pins and the
// note/control FSMs; each bit of INVERT_MASK marks an active-low input.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                NUM_CH         = DEFAULT_NUM_CH,
    parameter int                DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int                HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter int                REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD,
    parameter logic [NUM_CH-1:0] INVERT_MASK    = {NUM_CH{1'b0}}
) (
    input  logic              i_Clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] i_Bouncy,
    input  logic [NUM_CH-1:0] i_Repeat_En,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Held,
    output logic [NUM_CH-1:0] o_Repeat
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .HOLD_LIMIT     (HOLD_LIMIT),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .INVERT         (INVERT_MASK[g])
        ) u_ch (
            .clk_i       (i_Clk),
            .rst_ni      (reset_n),
            .bouncy_i    (i_Bouncy[g]),
            .repeat_en_i (i_Repeat_En[g]),
            .debounced_o (o_Debounced[g]),
            .rise_o      (o_Rise[g]),
            .fall_o      (o_Fall[g]),
            .held_o      (o_Held[g]),
            .repeat_o    (o_Repeat[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised bench for debounce_bank: bouncy key traffic, enable changes and
// short resets, compared cycle by cycle against a window/elapsed-time model.
module tb_debounce_bank;

    localparam int             NCH = 4;
    localparam int             DL  = 4;
    localparam int             HL  = 10;
    localparam int             RP  = 3;
    localparam logic [NCH-1:0] INV = 4'b0100;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] bouncy;
    logic [NCH-1:0] rep_en;
    logic [NCH-1:0] o_deb;
    logic [NCH-1:0] o_rise;
    logic [NCH-1:0] o_fall;
    logic [NCH-1:0] o_held;
    logic [NCH-1:0] o_rep;

    debounce_bank #(
        .NUM_CH         (NCH),
        .DEBOUNCE_LIMIT (DL),
        .HOLD_LIMIT     (HL),
        .REPEAT_PERIOD  (RP),
        .INVERT_MASK    (INV)
    ) dut (
        .i_Clk       (clk),
        .reset_n     (reset_n),
        .i_Bouncy    (bouncy),
        .i_Repeat_En (rep_en),
        .o_Debounced (o_deb),
        .o_Rise      (o_rise),
        .o_Fall      (o_fall),
        .o_Held      (o_held),
        .o_Repeat    (o_rep)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: synchroniser taps, recent synchronised samples, accepted
    // level and number of clocks elapsed since the press was accepted.
    bit             m_s1 [NCH];
    bit             m_s2 [NCH];
    bit             m_win [NCH][$];
    bit             m_deb [NCH];
    int             m_press [NCH];
    logic [NCH-1:0] e_deb, e_rise, e_fall, e_held, e_rep;
    int             rep_seen = 0;
    int             held_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit rst_n_in, input logic [NCH-1:0] raw, input logic [NCH-1:0] en);
        bit seen;
        bit stable;
        for (int ch = 0; ch < NCH; ch++) begin
            e_rise[ch] = 1'b0;
            e_fall[ch] = 1'b0;
            e_held[ch] = 1'b0;
            e_rep[ch]  = 1'b0;
            if (!rst_n_in) begin
                m_s1[ch]    = 1'b0;
                m_s2[ch]    = 1'b0;
                m_deb[ch]   = 1'b0;
                m_press[ch] = 0;
                m_win[ch].delete();
            end else begin
                seen     = m_s2[ch];
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw[ch] ^ INV[ch];
                m_win[ch].push_back(seen);
                if (m_win[ch].size() > DL) void'(m_win[ch].pop_front());
                // accept once the last DL synchronised samples all disagree with the level
                stable = (m_win[ch].size() == DL);
                foreach (m_win[ch][k]) if (m_win[ch][k] == m_deb[ch]) stable = 1'b0;
                if (stable) begin
                    m_deb[ch]  = ~m_deb[ch];
                    e_rise[ch] = m_deb[ch];
                    e_fall[ch] = ~m_deb[ch];
                end
                if (!m_deb[ch]) begin
                    m_press[ch] = 0;
                end else if (e_rise[ch]) begin
                    m_press[ch] = 0;
                end else begin
                    m_press[ch] = m_press[ch] + 1;
                    e_held[ch]  = (m_press[ch] >= HL);
                    e_rep[ch]   = en[ch] && (m_press[ch] >= HL) && (((m_press[ch] - HL) % RP) == 0);
                end
            end
            e_deb[ch] = m_deb[ch];
        end
    endtask

    task automatic compare_all();
        check_eq("debounced", 32'(o_deb), 32'(e_deb));
        check_eq("rise", 32'(o_rise), 32'(e_rise));
        check_eq("fall", 32'(o_fall), 32'(e_fall));
        check_eq("held", 32'(o_held), 32'(e_held));
        check_eq("repeat", 32'(o_rep), 32'(e_rep));
        check_eq("rise_fall_exclusive", 32'(o_rise & o_fall), 32'd0);
        if (e_rep != '0) rep_seen++;
        if (e_held != '0) held_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(reset_n, bouncy, rep_en);
        #1;
        compare_all();
    endtask

    logic [NCH-1:0] target;
    int             bounce_left [NCH];

    initial begin
        reset_n = 1'b0;
        bouncy  = 4'hF;
        rep_en  = 4'hF;
        target  = 4'hF;
        for (int ch = 0; ch < NCH; ch++) bounce_left[ch] = 0;

        repeat (3) cycle();
        reset_n = 1'b1;
        repeat (30) cycle();

        for (int cyc = 0; cyc < 5000; cyc++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 59) == 0) begin
                    target[ch]      = ~target[ch];
                    bounce_left[ch] = $urandom_range(0, 8);
                end
                if (bounce_left[ch] > 0) begin
                    bouncy[ch]      = 1'($urandom_range(0, 1));
                    bounce_left[ch] = bounce_left[ch] - 1;
                end else begin
                    bouncy[ch] = target[ch];
                end
            end
            if ($urandom_range(0, 149) == 0) rep_en = 4'($urandom);
            reset_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            cycle();
        end

        check_eq("stimulus_reached_held", 32'(held_seen > 0), 32'd1);
        check_eq("stimulus_reached_repeat", 32'(rep_seen > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
